// File: rtl/dma_pkg.sv
// Shared types and defaults for the mem_copy_dma bus initiator.
package dma_pkg;

  localparam int unsigned DMA_ADDR_W    = 7;
  localparam int unsigned DMA_DATA_W    = 8;
  localparam int unsigned DMA_SRAM_BASE = 32'h40;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    RD,
    WR,
    DONE
  } dma_state_t;

endpackage

// File: rtl/dma_beat_counter.sv
// Beat index for a copy, with source/destination address generation and the terminal-beat flag.
module dma_beat_counter
  import dma_pkg::*;
#(
  parameter int unsigned ADDR_W = DMA_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              inc,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  input  logic [ADDR_W:0]   len,
  output logic [ADDR_W-1:0] src_cur_c,
  output logic [ADDR_W-1:0] dst_cur_c,
  output logic [ADDR_W-1:0] src_next_c,
  output logic              last_c
);

  logic [ADDR_W:0] idx;
  logic [ADDR_W:0] idx_inc;

  assign idx_inc = idx + (ADDR_W+1)'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= '0;
    end else if (clear) begin
      idx <= '0;
    end else if (inc) begin
      idx <= idx_inc;
    end
  end

  // Addresses wrap modulo the map size; the range check upstream keeps dst from wrapping.
  assign src_cur_c  = src_base + idx[ADDR_W-1:0];
  assign dst_cur_c  = dst_base + idx[ADDR_W-1:0];
  assign src_next_c = src_base + idx_inc[ADDR_W-1:0];
  assign last_c     = (idx_inc == len);

endmodule

// File: rtl/mem_copy_dma.sv
// Single-master memory copy engine: one byte per RD/WR pair, range-checked destination, running checksum.
module mem_copy_dma
  import dma_pkg::*;
#(
  parameter int unsigned ADDR_W    = DMA_ADDR_W,
  parameter int unsigned DATA_W    = DMA_DATA_W,
  parameter int unsigned SRAM_BASE = DMA_SRAM_BASE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W:0]   len,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] checksum,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned EXT_W = ADDR_W + 2;

  dma_state_t        state;
  logic [ADDR_W-1:0] src_q;
  logic [ADDR_W-1:0] dst_q;
  logic [ADDR_W:0]   len_q;
  logic [DATA_W-1:0] rd_buf;

  logic              accept_c;
  logic              beat_inc_c;
  logic [ADDR_W-1:0] src_cur_c;
  logic [ADDR_W-1:0] dst_cur_c;
  logic [ADDR_W-1:0] src_next_c;
  logic              last_c;
  logic [EXT_W-1:0]  dst_end_c;
  logic              range_bad_c;

  assign accept_c   = (state == IDLE) && start;
  assign beat_inc_c = (state == WR);

  dma_beat_counter #(
    .ADDR_W (ADDR_W)
  ) u_beat (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (accept_c),
    .inc        (beat_inc_c),
    .src_base   (src_q),
    .dst_base   (dst_q),
    .len        (len_q),
    .src_cur_c  (src_cur_c),
    .dst_cur_c  (dst_cur_c),
    .src_next_c (src_next_c),
    .last_c     (last_c)
  );

  // Widened so dst+len-1 past the top of the map is seen rather than wrapped.
  assign dst_end_c   = EXT_W'(dst_q) + EXT_W'(len_q) - EXT_W'(1);
  assign range_bad_c = (EXT_W'(dst_q) < EXT_W'(SRAM_BASE)) ||
                       (dst_end_c > EXT_W'((2 ** ADDR_W) - 1));

  // Outputs are loaded for the state being entered, so they are valid throughout that state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      src_q     <= '0;
      dst_q     <= '0;
      len_q     <= '0;
      rd_buf    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      checksum  <= '0;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
    end else begin
      done   <= 1'b0;
      mem_we <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            src_q    <= src_addr;
            dst_q    <= dst_addr;
            len_q    <= len;
            err      <= 1'b0;
            checksum <= '0;
            busy     <= 1'b1;
            state    <= CHECK;
          end
        end
        CHECK: begin
          if (len_q == '0) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else if (range_bad_c) begin
            err   <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            mem_addr <= src_cur_c;
            state    <= RD;
          end
        end
        RD: begin
          rd_buf    <= mem_rdata;
          mem_wdata <= mem_rdata;
          mem_addr  <= dst_cur_c;
          mem_we    <= 1'b1;
          state     <= WR;
        end
        WR: begin
          checksum <= checksum + rd_buf;
          if (last_c) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            mem_addr <= src_next_c;
            state    <= RD;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
